// File: rtl/im_axi_read_master.sv
// Instruction-side AXI4 single-beat read master feeding the fetch stage (AXI master 0).
// Optional IM_LAST_HIT_EN: one-entry last-fetch tag that skips the bus on a repeated address.
module im_axi_read_master #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASTER_ID  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  im_read,
    input  logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_instruction,
    output logic                  if_stall,
    output logic                  bus_err,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  bus_err_q, bus_err_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  addr_match_c;
    logic                  tag_hit_c;

    // Single outstanding transaction: the ID and the last flag carry no information.
    logic unused_c;
    assign unused_c = ^{RID, RLAST};

    assign ARID           = ID_WIDTH'(MASTER_ID);
    assign ARLEN          = 4'd0;
    assign ARSIZE         = 3'b010;
    assign ARBURST        = 2'b01;
    assign ARADDR         = araddr_q;
    assign ARVALID        = arvalid_q;
    assign RREADY         = rready_q;
    assign im_instruction = instr_q;
    assign bus_err        = bus_err_q;

    assign addr_match_c = (im_addr == araddr_q);

`ifdef IM_LAST_HIT_EN
    logic                  tag_valid_q, tag_valid_d;
    logic [ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;

    assign tag_hit_c = tag_valid_q && (im_addr == tag_addr_q);

    // Tag mirrors im_instruction: dropped when a new fetch starts, set on a clean delivery.
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_addr_d  = tag_addr_q;
        if (state_q == S_IDLE && state_d == S_ADDR) begin
            tag_valid_d = 1'b0;
        end
        if (state_q == S_DONE && addr_match_c) begin
            tag_valid_d = !bus_err_q;
            tag_addr_d  = araddr_q;
        end
        if (bus_err_q) begin
            tag_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_addr_q  <= tag_addr_d;
        end
    end
`else
    assign tag_hit_c = 1'b0;
`endif

    // Stall releases only when delivered data belongs to the address fetch is asking for.
    assign if_stall = im_read && !((state_q == S_DONE && addr_match_c) ||
                                   (state_q == S_IDLE && tag_hit_c));

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        instr_d   = instr_q;
        bus_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (im_read && !tag_hit_c) begin
                    araddr_d = im_addr;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arvalid_q && ARREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (RVALID && rready_q) begin
                    instr_d   = RDATA;
                    bus_err_d = (RRESP != 2'b00);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // A redirect during the stall discards the stale beat and refetches.
                if (addr_match_c) begin
                    state_d = S_IDLE;
                end else begin
                    araddr_d = im_addr;
                    state_d  = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        arvalid_d = (state_d == S_ADDR);
        rready_d  = (state_d == S_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            instr_q   <= '0;
            bus_err_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            instr_q   <= instr_d;
            bus_err_q <= bus_err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

endmodule

// File: tb/tb_im_axi_read_master.sv
// Bench for im_axi_read_master: vector table plus hand-written redirect, drop and reset sequences.
// A small AXI slave with programmable AR/R delays answers from a fixed memory image.
module tb_im_axi_read_master;

    localparam logic [31:0] ERR_ADDR = 32'h0000_BAD0;
    localparam int BUDGET = 100;

    logic        clk;
    logic        rst;
    logic        im_read;
    logic [31:0] im_addr;
    logic [31:0] im_instruction;
    logic        if_stall;
    logic        bus_err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    im_axi_read_master dut (
        .clk(clk), .rst(rst), .im_read(im_read), .im_addr(im_addr),
        .im_instruction(im_instruction), .if_stall(if_stall), .bus_err(bus_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ar_dly;
        int          r_dly;
        logic [31:0] exp_instr;
        int          exp_err;
        int          exp_ar;
        int          exp_stall;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    int          ar_dly = 0;
    int          r_dly  = 0;
    int          ar_hs  = 0;
    int          err_cycles = 0;
    int          stab_viol  = 0;
    int          const_viol = 0;
    logic [31:0] rd_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == ERR_ADDR) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI slave: decisions made on the falling edge for the following rising edge.
    initial begin
        int          ar_cnt;
        int          r_cnt;
        logic        ar_pend;
        logic [31:0] ar_prev;
        ar_cnt = 0; r_cnt = 0; ar_pend = 1'b0; ar_prev = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RID = '0; RLAST = 1'b0;
        forever begin
            @(negedge clk);
            if (ARVALID && (ARLEN != 4'd0 || ARSIZE != 3'b010 || ARBURST != 2'b01 || ARID != 4'd0))
                const_viol++;
            if (ar_pend && (!ARVALID || ARADDR != ar_prev))
                stab_viol++;
            if (rst) begin
                ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
                ar_cnt = 0; r_cnt = 0; ar_pend = 1'b0;
            end else begin
                if (ARVALID) begin
                    if (ar_cnt >= ar_dly) begin
                        ARREADY = 1'b1;
                        ar_hs++;
                        rd_addr = ARADDR;
                    end else begin
                        ARREADY = 1'b0;
                        ar_cnt++;
                    end
                end else begin
                    ARREADY = 1'b0;
                    ar_cnt  = 0;
                end
                ar_pend = ARVALID && !ARREADY;
                ar_prev = ARADDR;
                if (RREADY) begin
                    if (r_cnt >= r_dly) begin
                        RVALID = 1'b1;
                        RLAST  = 1'b1;
                        RDATA  = mem_word(rd_addr);
                        RRESP  = (rd_addr == ERR_ADDR) ? 2'b10 : 2'b00;
                    end else begin
                        RVALID = 1'b0;
                        r_cnt++;
                    end
                end else begin
                    RVALID = 1'b0;
                    RLAST  = 1'b0;
                    r_cnt  = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_err) err_cycles++;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          err0;
        int          ar0;
        logic [31:0] exp;
        ar_dly = v.ar_dly;
        r_dly  = v.r_dly;
        err0   = err_cycles;
        ar0    = ar_hs;
        im_read = 1'b1;
        im_addr = v.addr;
        exp_q.push_back(v.exp_instr);
        cyc = 0;
        #1;
        while (if_stall && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        if (if_stall) begin
            n_cmp++;
            n_fail++;
            $display("FAIL vec%0d timeout: if_stall still 1 after %0d cycles", idx, cyc);
        end
        exp = exp_q.pop_front();
        check($sformatf("vec%0d instr", idx), im_instruction, exp);
        check($sformatf("vec%0d stall_cycles", idx), cyc, v.exp_stall);
        im_read = 1'b0;
        @(negedge clk);
        #1;
        check($sformatf("vec%0d bus_err_cycles", idx), err_cycles - err0, v.exp_err);
        check($sformatf("vec%0d ar_handshakes", idx), ar_hs - ar0, v.exp_ar);
        check($sformatf("vec%0d arvalid_after", idx), ARVALID, 1'b0);
        check($sformatf("vec%0d instr_hold", idx), im_instruction, exp);
    endtask

    initial begin
        vec_t        vecs[7];
        vec_t        vpost;
        int          cyc;
        int          ar0;
        logic        stall_seen;
        logic [31:0] exp;

        vecs[0] = '{addr: 32'h0000_0000, ar_dly: 0, r_dly: 0, exp_instr: 32'h0000_0013,
                    exp_err: 0, exp_ar: 1, exp_stall: 3};
        vecs[1] = '{addr: 32'h0000_0004, ar_dly: 5, r_dly: 0, exp_instr: mem_word(32'h4),
                    exp_err: 0, exp_ar: 1, exp_stall: 8};
        vecs[2] = '{addr: 32'h0000_0008, ar_dly: 0, r_dly: 3, exp_instr: mem_word(32'h8),
                    exp_err: 0, exp_ar: 1, exp_stall: 6};
        vecs[3] = '{addr: ERR_ADDR, ar_dly: 1, r_dly: 1, exp_instr: 32'hDEAD_BEEF,
                    exp_err: 1, exp_ar: 1, exp_stall: 5};
        vecs[4] = '{addr: 32'h0000_0040, ar_dly: 0, r_dly: 0, exp_instr: mem_word(32'h40),
                    exp_err: 0, exp_ar: 1, exp_stall: 3};
`ifdef IM_LAST_HIT_EN
        vecs[5] = '{addr: 32'h0000_0040, ar_dly: 0, r_dly: 0, exp_instr: mem_word(32'h40),
                    exp_err: 0, exp_ar: 0, exp_stall: 0};
`else
        vecs[5] = '{addr: 32'h0000_0040, ar_dly: 0, r_dly: 0, exp_instr: mem_word(32'h40),
                    exp_err: 0, exp_ar: 1, exp_stall: 3};
`endif
        vecs[6] = '{addr: 32'hFFFF_FFFC, ar_dly: 2, r_dly: 2, exp_instr: mem_word(32'hFFFF_FFFC),
                    exp_err: 0, exp_ar: 1, exp_stall: 7};
        vpost   = '{addr: 32'h0000_000C, ar_dly: 0, r_dly: 0, exp_instr: mem_word(32'hC),
                    exp_err: 0, exp_ar: 1, exp_stall: 3};

        rst = 1'b1;
        im_read = 1'b0;
        im_addr = '0;
        repeat (3) @(negedge clk);
        check("reset arvalid", ARVALID, 1'b0);
        check("reset rready", RREADY, 1'b0);
        check("reset araddr", ARADDR, 32'h0);
        check("reset instr", im_instruction, 32'h0);
        check("reset bus_err", bus_err, 1'b0);
        check("reset if_stall", if_stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Redirect while the first read is in DATA: the stale beat must not be delivered.
        ar_dly = 0;
        r_dly  = 1;
        ar0    = ar_hs;
        im_read = 1'b1;
        im_addr = 32'h0000_0100;
        cyc = 0;
        while (!RREADY && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("redir reach_data", RREADY, 1'b1);
        im_addr = 32'h0000_0200;
        exp_q.push_back(mem_word(32'h200));
        cyc = 0;
        #1;
        while (if_stall && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        check("redir instr", im_instruction, exp);
        check("redir stall_cycles", cyc, 6);
        check("redir ar_handshakes", ar_hs - ar0, 2);
        check("redir second_araddr", rd_addr, 32'h0000_0200);
        im_read = 1'b0;
        @(negedge clk);

        // im_read dropped in ADDR: transaction completes, stall stays low, no refetch.
        ar_dly = 1;
        r_dly  = 1;
        im_read = 1'b1;
        im_addr = 32'h0000_0500;
        exp_q.push_back(mem_word(32'h500));
        @(negedge clk);
        im_read = 1'b0;
        stall_seen = 1'b0;
        cyc = 0;
        #1;
        while (im_instruction !== mem_word(32'h500) && cyc < BUDGET) begin
            if (if_stall) stall_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        check("drop instr", im_instruction, exp);
        check("drop stall_seen", stall_seen, 1'b0);
        @(negedge clk);
        #1;
        check("drop idle_arvalid", ARVALID, 1'b0);
        check("drop idle_rready", RREADY, 1'b0);

        // Synchronous reset while waiting in DATA.
        ar_dly = 0;
        r_dly  = 50;
        im_read = 1'b1;
        im_addr = 32'h0000_0300;
        cyc = 0;
        while (!RREADY && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("rst reach_data", RREADY, 1'b1);
        rst = 1'b1;
        im_read = 1'b0;
        @(negedge clk);
        #1;
        check("rst arvalid", ARVALID, 1'b0);
        check("rst rready", RREADY, 1'b0);
        check("rst instr", im_instruction, 32'h0);
        check("rst araddr", ARADDR, 32'h0);
        check("rst bus_err", bus_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vpost, 7);

        check("arvalid/araddr stability violations", stab_viol, 0);
        check("constant AR field violations", const_viol, 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/im_axi_read_master.md
Name: im_axi_read_master

Overview:
- Instruction-side AXI4 read master placed directly upstream of the fetch stage.
- Turns the fetch stage's IM_read/IM_addr request into a single-beat AXI read.
- Returns the 32-bit instruction and drives the IF stall (AXI_IF_stall) that the fetch stage and PC consume.
- Connects to the AXI interconnect as master 0.

Parameters:
ID_WIDTH, 4, width of ARID/RID
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, instruction/data width
MASTER_ID, 0, constant value driven on ARID

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
im_read  input  1  fetch request (IM_read from fetch stage)
im_addr  input  ADDR_WIDTH  fetch address (IM_addr, may change while stalled)
im_instruction  output  DATA_WIDTH  returned instruction, registered
if_stall  output  1  AXI_IF_stall to fetch stage/PC, combinational
bus_err  output  1  one-cycle pulse on non-OKAY RRESP
ARID  output  ID_WIDTH  = MASTER_ID
ARADDR  output  ADDR_WIDTH  latched request address
ARLEN  output  4  constant 0
ARSIZE  output  3  constant 3'b010
ARBURST  output  2  constant 2'b01 (INCR)
ARVALID  output  1  read address valid
ARREADY  input  1  read address ready
RID  input  ID_WIDTH  read ID (ignored, single outstanding)
RDATA  input  DATA_WIDTH  read data
RRESP  input  2  read response
RLAST  input  1  last beat (always 1 for ARLEN=0)
RVALID  input  1  read data valid
RREADY  output  1  read data ready

Behaviour:
- States: IDLE, ADDR, DATA, DONE. One outstanding transaction at a time.
- Reset (synchronous, any state): state=IDLE; ARVALID=0, RREADY=0, ARADDR=0, im_instruction=0, bus_err=0.
- IDLE:
  - If im_read=1: latch im_addr into ARADDR and go to ADDR.
  - Else stay in IDLE.
- ADDR:
  - ARVALID=1. ARADDR is held stable until ARVALID&&ARREADY.
  - On the handshake go to DATA.
- DATA:
  - RREADY=1.
  - On RVALID&&RREADY: im_instruction<=RDATA and go to DONE.
  - If RRESP!=2'b00, additionally pulse bus_err for 1 cycle; im_instruction still takes RDATA.
- DONE, one cycle:
  - If im_addr==ARADDR: if_stall=0 so the fetch stage latches im_instruction; next state is IDLE.
  - If im_addr!=ARADDR (a jump/branch redirected during the stall): if_stall stays 1, ARADDR<=im_addr, next state is ADDR. The stale data is discarded.
- if_stall = im_read && !(state==DONE && im_addr==ARADDR). if_stall is 0 whenever im_read=0.
- Minimum latency is 4 cycles from request to if_stall=0, with ARREADY and RVALID each arriving after 1 cycle: IDLE, ADDR, DATA, DONE.
- im_addr changes during ADDR or DATA are ignored; the AXI transaction in flight is never aborted.
- im_instruction holds its value outside DONE updates.
- im_read dropping mid-transaction: the transaction still completes to DONE, and if_stall stays 0.

Optional Feature:
IM_LAST_HIT_EN
- Defined: a one-entry tag register (valid bit + address) records the last completed fetch.
  - In IDLE, if im_read=1 and im_addr matches a valid tag, if_stall=0 in that same cycle and no AXI transaction is issued.
  - Tag valid is cleared by reset and by bus_err.
- Not defined: every request goes through the full AXI sequence; no tag logic is present.

Test Plan:
1. Reset, then im_read=1, im_addr=0x0000_0000, slave ARREADY/RVALID 1 cycle later, RDATA=0x0000_0013 -> ARADDR=0x0, ARLEN=0; if_stall=1 for 3 cycles then 0 in DONE; im_instruction=0x0000_0013.
2. ARREADY delayed 5 cycles -> ARVALID and ARADDR stay stable for all 5 cycles; exactly one AR handshake.
3. Fetch 0x100; change im_addr to 0x200 during DATA -> DONE keeps if_stall=1 and a second AR with ARADDR=0x200 is issued; data from 0x200 is delivered with if_stall=0.
4. RRESP=2'b10 with RDATA=0xDEADBEEF -> bus_err high exactly 1 cycle; im_instruction=0xDEADBEEF.
5. rst asserted while in DATA -> next cycle state IDLE; ARVALID=0, RREADY=0, im_instruction=0.
6. IM_LAST_HIT_EN defined: fetch 0x40, then re-request 0x40 from IDLE -> if_stall=0 same cycle, no ARVALID. Without the macro: full transaction is issued.
